util_shift_unloader: RTL
========================

Name: util_shift_unloader

Overview:
- De-skew stage at the output edge of the systolic array; the inverse of the staggering input loader.
- Result lane k of a row leaves the array k cycles after lane 0. This block delays each lane so that all lanes of a row line up again.
- Each realigned row is repacked into one FIFO_WIDTH vector and buffered in a small FIFO. The FIFO drains over a valid/ready handshake toward the AXI/DMA write-back path.

Parameters:
- ELEMENT_WIDTH, 16, bits per lane element.
- ELEMENT_COUNT, 4, lane count N (must be >= 2).
- FIFO_DEPTH, 4, aligned rows buffered (power of two, >= 2).
- FULL_WIDTH, ELEMENT_WIDTH*ELEMENT_COUNT, localparam, packed row width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  high in cycle t: lane 0 of a new row is present on packed_in.
- packed_in  input  FULL_WIDTH  skewed lanes; lane k occupies bits [k*ELEMENT_WIDTH +: ELEMENT_WIDTH] and belongs to the row whose in_valid was high in cycle (current-k).
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  FULL_WIDTH  aligned row; lane k in bits [k*ELEMENT_WIDTH +: ELEMENT_WIDTH].
- fill_level  output  $clog2(FIFO_DEPTH)+1  rows currently stored.
- overflow  output  1  sticky: at least one row was dropped.

Behaviour:
- Reset state: all delay registers, valid pipeline, FIFO pointers and fill_level are 0; overflow=0; out_valid=0; out_data=0.
- Deskew:
  - Lane k passes through exactly N-1-k free-running registers; lane N-1 is combinational.
  - in_valid passes through an N-1 stage shift pipeline.
  - There is no enable: the array streams continuously, and the pipeline shifts every cycle.
- Row-complete strobe: wr_en = last valid stage. For in_valid at cycle t, wr_en is high in cycle t+N-1 and the aligned row is {lane N-1 at t+N-1, ..., lane 0 at t}.
- FIFO write on the edge ending cycle t+N-1. If the FIFO was empty, out_valid=1 in cycle t+N (latency N cycles).
- Read: a transfer occurs when out_valid && out_ready. The head pointer advances and the next entry is presented the following cycle.
- out_data is the head entry when out_valid=1 and is forced to 0 when empty. out_data is stable while out_valid && !out_ready.
- Full FIFO:
  - wr_en with fill_level==FIFO_DEPTH and no read in the same cycle: the row is dropped, overflow is set, stored data is unchanged.
  - Simultaneous read and write when full: both are accepted and fill_level stays at FIFO_DEPTH.
- Simultaneous read and write when empty: no read occurs (out_valid=0). The write is stored and fill_level becomes 1.
- Pointers wrap modulo FIFO_DEPTH. fill_level changes by -1, 0 or +1 per cycle.
- Back-to-back in_valid every cycle is legal. Each cycle yields one aligned row N-1 cycles later.
- overflow clears only on rst.
- rst mid-stream:
  - In-flight skewed rows and buffered rows are discarded.
  - Lanes of a pre-reset row that arrive after rst deasserts are never written, because the valid pipeline was cleared.
  - The first post-reset in_valid is handled normally.
- Assertion: X on in_valid or out_ready after reset is an error.

Test Plan:
- Single row (N=4, W=16): in_valid at t=10. Lanes 0..3 = 0x1111, 0x2222, 0x3333, 0x4444, presented at t=10..13 respectively. Required: out_valid rises at t=14 with out_data=0x4444_3333_2222_1111 and fill_level=1. With out_ready=1 at t=14, out_valid=0 at t=15.
- Streaming: rows r0..r7 with in_valid every cycle, lane k of row r = r*16+k, out_ready held 1. Required: 8 aligned rows in order on consecutive cycles starting at t0+4, and fill_level never exceeds 1.
- Backpressure and overflow (FIFO_DEPTH=4): out_ready=0, 6 rows issued. Required: fill_level stops at 4; overflow=1 from the cycle after the 5th row's wr_en. Then out_ready=1: rows 0..3 drain, out_valid=0 after 4 transfers, overflow stays 1.
- Full with simultaneous read and write: fill FIFO to 4, then out_ready=1 in the same cycle a 5th row's wr_en fires. Required: no drop, overflow=0, fill_level=4; rows 1..4 follow.
- Stall stability: out_ready toggles 0,1,0,0,1 against 3 buffered rows. Required: out_data is unchanged during every out_ready=0 cycle, and each row appears exactly once.
- Reset mid-operation: assert rst for 1 cycle at t+2 of a row and while 2 rows are buffered. Required: next cycle out_valid=0, fill_level=0, overflow=0, and the partial row is never output. A fresh row issued after reset emerges N cycles later with correct data.

Source files
------------

// File: rtl/util_shift_unloader.sv
`timescale 1ns/1ps
// util_shift_unloader: output-edge de-skew for the systolic array.
// Lane k of a row leaves the array k cycles after lane 0. Each lane is delayed
// so that a complete row lines up again. The aligned row is then pushed into
// a small FIFO that drains over a valid/ready handshake toward write-back.
module util_shift_unloader #(
   parameter int ELEMENT_WIDTH = 16,
   parameter int ELEMENT_COUNT = 4,
   parameter int FIFO_DEPTH    = 4,
   localparam int FULL_WIDTH   = ELEMENT_WIDTH * ELEMENT_COUNT
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   input  logic [FULL_WIDTH-1:0]           packed_in,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [FULL_WIDTH-1:0]           out_data,
   output logic [$clog2(FIFO_DEPTH):0]     fill_level,
   output logic                            overflow
);

   localparam int N     = ELEMENT_COUNT;
   localparam int EW    = ELEMENT_WIDTH;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // ---- stage p0 -> p1: per-lane deskew, lane k delayed by N-1-k cycles ----
   logic [FULL_WIDTH-1:0] row_p1;
   logic [N-2:0]          vld_p;
   logic                  wr_en;

   for (genvar k = 0; k < N - 1; k++) begin : g_lane
      localparam int D = N - 1 - k;
      logic [EW-1:0] lane_p [D];

      // Free-running delay line for lane k; shifts every cycle with no enable.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < D; i++) lane_p[i] <= '0;
         end else begin
            lane_p[0] <= packed_in[k*EW +: EW];
            for (int i = 1; i < D; i++) lane_p[i] <= lane_p[i-1];
         end
      end

      assign row_p1[k*EW +: EW] = lane_p[D-1];
   end

   // The last lane arrives already aligned, so it feeds the row directly.
   assign row_p1[(N-1)*EW +: EW] = packed_in[(N-1)*EW +: EW];

   // Valid pipeline of N-1 stages; its last stage marks a completed row.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= in_valid;
         for (int i = 1; i < N - 1; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   assign wr_en = vld_p[N-2];

   // ---- stage p1 -> FIFO: buffer aligned rows, drain over valid/ready ----
   logic [FULL_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  full;
   logic                  rd_fire;
   logic                  wr_accept;
   logic                  wr_drop;

   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign out_valid = (count != '0);
   assign rd_fire   = out_valid && out_ready;
   // A full FIFO still takes a row when the head leaves in the same cycle.
   assign wr_accept = wr_en && (!full || rd_fire);
   assign wr_drop   = wr_en && full && !rd_fire;

   // Row storage; contents are never observed unless the slot holds a row.
   always_ff @(posedge clk) begin
      if (wr_accept) mem[wr_ptr] <= row_p1;
   end

   // Pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
         if (rd_fire)   rd_ptr <= rd_ptr + 1'b1;
         if (wr_accept && !rd_fire)      count <= count + 1'b1;
         else if (!wr_accept && rd_fire) count <= count - 1'b1;
         if (wr_drop) overflow <= 1'b1;
      end
   end

   assign out_data   = out_valid ? mem[rd_ptr] : '0;
   assign fill_level = count;

`ifndef SYNTHESIS
   a_ctrl_known: assert property (@(posedge clk) disable iff (rst)
      !$isunknown({in_valid, out_ready}));
`endif

endmodule
